// File: rtl/period_meter.sv
// period_meter: measures the TICK period and its high time in CLOCK cycles.
// All state is updated on the falling edge of CLOCK. A period is reported
// only after two consecutive rising edges of TICK. If no edge arrives before
// the counter saturates, OVF is raised and the last good PERIOD is kept.
module period_meter #(
  parameter int W      = 16,
  parameter int EXPECT = 5
) (
  input  logic         CLOCK,
  input  logic         CLEAR,
  input  logic         TICK,
  output logic [W-1:0] PERIOD,
  output logic [W-1:0] HIGHW,
  output logic         VALID,
  output logic         OVF,
  output logic         MATCH
);

  localparam logic [W-1:0] CMAX  = '1;
  localparam logic [W-1:0] ONE   = W'(1);
  localparam logic [W-1:0] EXP_W = W'(EXPECT);

  typedef enum logic [1:0] {IDLE, MEASURE, OVER} state_t;

  state_t       state;
  logic         tick_d;
  logic [W-1:0] cnt;
  logic [W-1:0] hcnt;
  logic         edge_det;

  // A rising edge is TICK high now while the previous sample was low.
  // tick_d resets to 1, so TICK held high through CLEAR is not an edge.
  assign edge_det = TICK & ~tick_d;

  // MATCH follows the held period and is suppressed while overflowed.
  assign MATCH = (PERIOD == EXP_W) && !OVF;

  // Measurement FSM: count between rising edges, latch on edge, saturate on timeout.
  always_ff @(negedge CLOCK) begin
    if (CLEAR) begin
      state  <= IDLE;
      tick_d <= 1'b1;
      cnt    <= '0;
      hcnt   <= '0;
      PERIOD <= '0;
      HIGHW  <= '0;
      VALID  <= 1'b0;
      OVF    <= 1'b0;
    end else begin
      tick_d <= TICK;
      VALID  <= 1'b0;
      case (state)
        IDLE: begin
          // First edge only starts a measurement; nothing to report yet.
          if (edge_det) begin
            state <= MEASURE;
            cnt   <= ONE;
            hcnt  <= ONE;
          end
        end
        MEASURE: begin
          if (edge_det) begin
            PERIOD <= cnt;
            HIGHW  <= hcnt;
            VALID  <= 1'b1;
            OVF    <= 1'b0;
            cnt    <= ONE;
            hcnt   <= ONE;
          end else if (cnt == CMAX) begin
            // Counter full with no edge: hold counts, keep old results.
            state <= OVER;
            OVF   <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
            // hcnt never exceeds cnt, but saturate anyway so it cannot wrap.
            if (TICK && (hcnt != CMAX)) hcnt <= hcnt + ONE;
          end
        end
        OVER: begin
          // Restart without reporting; OVF clears on the next VALID.
          if (edge_det) begin
            state <= MEASURE;
            cnt   <= ONE;
            hcnt  <= ONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 SHALL take parameter W, default 16: width of the period and high-width counters.
REQ-002 SHALL take parameter EXPECT, default 5: period value, in CLOCK cycles, that sets MATCH.
REQ-003 SHALL have port CLOCK  input  1: the single clock; all state updates on the falling edge of CLOCK.
REQ-004 SHALL have port CLEAR  input  1: reset, synchronous and active-high, sampled on the CLOCK falling edge.
REQ-005 SHALL have port TICK  input  1: pulse train to measure, synchronous to CLOCK (e.g. divider OUT).
REQ-006 SHALL have port PERIOD  output  W: CLOCK cycles between the last two TICK rising edges.
REQ-007 SHALL have port HIGHW  output  W: cycles TICK was sampled high within that same period.
REQ-008 SHALL have port VALID  output  1: one-cycle strobe; PERIOD and HIGHW were just updated.
REQ-009 SHALL have port OVF  output  1: no TICK edge arrived before the counter saturated.
REQ-010 SHALL have port MATCH  output  1: high while the held PERIOD equals EXPECT and OVF is low.

Function
REQ-011 SHALL register TICK into TICK_D every cycle; rising edge (EDGE) = TICK==1 and TICK_D==0 in the same cycle.
REQ-012 SHALL implement three states: IDLE (no edge yet), MEASURE (counting between edges), OVER (saturated).
REQ-013 IDLE: on EDGE, go to MEASURE, CNT<=1, HCNT<=1; no VALID; PERIOD and HIGHW unchanged.
REQ-014 MEASURE without EDGE: CNT<=CNT+1, HCNT<=HCNT+TICK.
REQ-015 MEASURE with EDGE: PERIOD<=CNT, HIGHW<=HCNT, VALID<=1 for exactly one cycle, OVF<=0, CNT<=1, HCNT<=1.
REQ-016 Latency: PERIOD, HIGHW and VALID change on the same falling edge that samples EDGE, one register stage after TICK.
REQ-017 MEASURE with CNT==2^W-1 and no EDGE: go to OVER, OVF<=1, CNT and HCNT hold; PERIOD and HIGHW hold their old values.
REQ-018 OVER: on EDGE, go to MEASURE, CNT<=1, HCNT<=1, no VALID; OVF stays 1 until the next VALID.
REQ-019 HCNT SHALL saturate at 2^W-1 and never wrap; HIGHW<=CNT SHALL always hold at latch time.
REQ-020 A TICK held constantly high SHALL produce no further EDGE and SHALL end in OVER.
REQ-021 MATCH SHALL be combinational from the held PERIOD and OVF; EXPECT is compared at W bits.
REQ-022 VALID SHALL be low in every cycle where no EDGE was sampled in MEASURE.

Reset
REQ-023 CLEAR=1 SHALL force state IDLE, CNT=0, HCNT=0, PERIOD=0, HIGHW=0, VALID=0, OVF=0, with TICK_D=1.
REQ-024 CLEAR SHALL take priority over EDGE and saturation in the same cycle.
REQ-025 A CLEAR mid-measurement SHALL discard partial counts; the first EDGE after CLEAR only restarts measurement.
REQ-026 Because TICK_D resets to 1, a TICK held high through CLEAR deassertion SHALL NOT count as an EDGE.

Verification
REQ-027 Scenario: TICK = 1-high/4-low (divide-by-5), W=16 -> first VALID on the 2nd edge, then every 5 cycles; PERIOD=5, HIGHW=1, MATCH=1.
REQ-028 Scenario: switch TICK to 3-high/7-low -> the first VALID spanning the change reports the mixed count; afterwards PERIOD=10, HIGHW=3, MATCH=0.
REQ-029 Scenario: W=4, TICK stops after one edge -> CNT reaches 15, OVF=1 at the next edge; PERIOD unchanged; after restart, the 2nd edge gives VALID with OVF=0.
REQ-030 Scenario: TICK stuck high from mid-stream -> no VALID, OVF=1 after 2^W-1 cycles; a later low-high transition restarts without VALID.
REQ-031 Scenario: CLEAR pulsed 2 cycles after an edge, TICK held high across CLEAR -> all outputs 0, no EDGE on CLEAR release; VALID comes only on the 2nd subsequent edge.
REQ-032 Scenario: CLEAR asserted in the same cycle as EDGE -> CLEAR wins; VALID=0 and PERIOD=0 the next cycle.
